prio_encode_scan: RTL

Parametrised, registered successor to the 8-to-3 encoder/seven-segment path. It priority-encodes an N_IN-bit request vector, where the highest set index wins. It registers the index with a valid flag and can optionally latch the first hit until cleared. The encoded value is shown as hex on a time-multiplexed N_DIG-digit seven-segment display. It sits between board switches/keys or internal request lines and the display pins.

---
 rtl/seg_pkg.sv | 17 +
 rtl/seg_hex_dec.sv | 14 +
 rtl/prio_encode_scan.sv | 99 +++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants and types for the priority encoder / seven-segment scanner
package seg_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int MODE_TRACK = 0;
  localparam int MODE_LATCH = 1;

  typedef enum logic {ST_IDLE, ST_HELD} state_t;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg_hex_dec.sv
// rtl/seg_hex_dec.sv - combinational hex nibble to active-low seven-segment decoder
module seg_hex_dec
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : HEX_SEG[nibble];
  end

endmodule

// File: rtl/prio_encode_scan.sv
// rtl/prio_encode_scan.sv - registered highest-index priority encoder with scanned hex display
module prio_encode_scan
  import seg_pkg::*;
#(
  parameter int N_IN       = 16,
  parameter int N_DIG      = 2,
  parameter int SCAN_DIV   = 1000,
  parameter int LATCH_MODE = 0,
  localparam int W_OUT     = $clog2(N_IN)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_IN-1:0]  i_code,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [W_OUT-1:0] o_code,
  output logic             o_valid,
  output logic [7:0]       o_seg,
  output logic [N_DIG-1:0] o_dig_sel
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIG_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int PAD_W = (W_OUT > 4 * N_DIG) ? W_OUT : 4 * N_DIG;

  logic [W_OUT-1:0] idx;
  logic             hit;
  state_t           state;
  logic [CNT_W-1:0] scan_cnt;
  logic [DIG_W-1:0] dig_idx;
  logic [PAD_W-1:0] code_pad;
  logic [3:0]       nibble;
  logic [7:0]       seg_next;

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (i_code[i]) idx = W_OUT'(i);
    end
  end

  assign hit = i_en & (|i_code);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_code  <= '0;
      o_valid <= 1'b0;
      state   <= ST_IDLE;
    end else if (LATCH_MODE == MODE_TRACK) begin
      o_code  <= hit ? idx : '0;
      o_valid <= hit;
    end else if (i_clr) begin
      // Clear beats a simultaneous hit; the request is re-evaluated next cycle.
      o_code  <= '0;
      o_valid <= 1'b0;
      state   <= ST_IDLE;
    end else if (state == ST_IDLE && hit) begin
      o_code  <= idx;
      o_valid <= 1'b1;
      state   <= ST_HELD;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      dig_idx  <= (dig_idx == DIG_W'(N_DIG - 1)) ? '0 : dig_idx + DIG_W'(1);
    end else begin
      scan_cnt <= scan_cnt + CNT_W'(1);
    end
  end

  assign o_dig_sel = ~(N_DIG'(1) << dig_idx);

  assign code_pad = PAD_W'(o_code);

  always_comb begin
    nibble = '0;
    for (int k = 0; k < N_DIG; k++) begin
      if (dig_idx == DIG_W'(k)) nibble = code_pad[4*k +: 4];
    end
  end

  seg_hex_dec u_dec (
    .nibble (nibble),
    .blank  (~o_valid),
    .seg    (seg_next)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) o_seg <= SEG_BLANK;
    else          o_seg <= seg_next;
  end

endmodule
